// File: rtl/uart_frame_demux.sv
// uart_frame_demux
//  Receive-side frame decoder for the player-2 board. It collects the five
//  tagged 16-bit words that make up one game-state frame from the player-1
//  board. After the last word it updates every game-state output in one cycle.
//  Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   data_in[15:0]            [15:12] tag, [11:0] payload
//   data_valid               1-cycle strobe qualifying data_in
//   pl1_posx/pl1_posy        remote player position (12 bit)
//   ball_posx/ball_posy      ball position (12 bit)
//   pl1_score/pl2_score      binary scores (4 bit)
//   flag_point, end_game     status flags
//   whistle                  pulse on a 0->1 edge of the committed whistle bit
//   frame_valid, frame_err   1-cycle pulses on commit / discarded frame
//   link_ok                  frames arriving within LINK_TIMEOUT
module uart_frame_demux #(
  parameter int unsigned WORD_TIMEOUT = 65000,
  parameter int unsigned LINK_TIMEOUT = 6500000,
  parameter logic [11:0] RST_PL1_X    = 12'd50,
  parameter logic [11:0] RST_PL1_Y    = 12'd679
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] data_in,
  input  logic        data_valid,
  output logic [11:0] pl1_posx,
  output logic [11:0] pl1_posy,
  output logic [11:0] ball_posx,
  output logic [11:0] ball_posy,
  output logic [3:0]  pl1_score,
  output logic [3:0]  pl2_score,
  output logic        flag_point,
  output logic        end_game,
  output logic        whistle,
  output logic        frame_valid,
  output logic        frame_err,
  output logic        link_ok
);

  localparam int unsigned WW = $clog2(WORD_TIMEOUT + 1);
  localparam int unsigned LW = $clog2(LINK_TIMEOUT + 1);
  localparam logic [WW-1:0] WT_LAST = WW'(WORD_TIMEOUT - 1);
  localparam logic [LW-1:0] LT_MAX  = LW'(LINK_TIMEOUT);

  typedef enum logic {S_SYNC, S_COLLECT} state_t;

  state_t        state_q, state_d;
  logic [2:0]    exp_q, exp_d;
  logic [WW-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] lcnt_q, lcnt_d;
  logic [11:0]   sh_px_q, sh_px_d, sh_py_q, sh_py_d;
  logic [11:0]   sh_bx_q, sh_bx_d, sh_by_q, sh_by_d;
  logic [11:0]   px_q, px_d, py_q, py_d, bx_q, bx_d, by_q, by_d;
  logic [3:0]    s1_q, s1_d, s2_q, s2_d;
  logic          fp_q, fp_d, eg_q, eg_d;
  logic          wh_q, wh_d, wprev_q, wprev_d;
  logic          fv_q, fv_d, fe_q, fe_d, lk_q, lk_d;
  logic          commit;
  logic [3:0]    tag;
  logic [11:0]   pay;

  assign tag = data_in[15:12];
  assign pay = data_in[11:0];

  always_comb begin
    state_d = state_q;
    exp_d   = exp_q;
    wcnt_d  = wcnt_q;
    lcnt_d  = lcnt_q;
    sh_px_d = sh_px_q;
    sh_py_d = sh_py_q;
    sh_bx_d = sh_bx_q;
    sh_by_d = sh_by_q;
    px_d    = px_q;
    py_d    = py_q;
    bx_d    = bx_q;
    by_d    = by_q;
    s1_d    = s1_q;
    s2_d    = s2_q;
    fp_d    = fp_q;
    eg_d    = eg_q;
    wprev_d = wprev_q;
    lk_d    = lk_q;
    wh_d    = 1'b0;
    fv_d    = 1'b0;
    fe_d    = 1'b0;
    commit  = 1'b0;

    case (state_q)
      S_SYNC: begin
        wcnt_d = '0;
        if (data_valid && tag == 4'd0) begin
          sh_px_d = pay;
          exp_d   = 3'd1;
          state_d = S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (data_valid) begin
          // An arriving word always beats a timeout in the same cycle.
          wcnt_d = '0;
          if (tag == {1'b0, exp_q}) begin
            case (exp_q)
              3'd1:    sh_py_d = pay;
              3'd2:    sh_bx_d = pay;
              3'd3:    sh_by_d = pay;
              default: commit  = 1'b1;
            endcase
            if (exp_q == 3'd4) begin
              exp_d   = 3'd0;
              state_d = S_SYNC;
            end else begin
              exp_d = exp_q + 3'd1;
            end
          end else if (tag == 4'd0) begin
            // A new frame start aborts the current frame and begins another.
            fe_d    = 1'b1;
            sh_px_d = pay;
            exp_d   = 3'd1;
          end else begin
            fe_d    = 1'b1;
            exp_d   = 3'd0;
            state_d = S_SYNC;
          end
        end else if (wcnt_q == WT_LAST) begin
          fe_d    = 1'b1;
          wcnt_d  = '0;
          exp_d   = 3'd0;
          state_d = S_SYNC;
        end else begin
          wcnt_d = wcnt_q + 1'b1;
        end
      end
      default: state_d = S_SYNC;
    endcase

    if (commit) begin
      px_d    = sh_px_q;
      py_d    = sh_py_q;
      bx_d    = sh_bx_q;
      by_d    = sh_by_q;
      s1_d    = pay[11:8];
      s2_d    = pay[7:4];
      fp_d    = pay[3];
      eg_d    = pay[2];
      wh_d    = pay[1] & ~wprev_q;
      wprev_d = pay[1];
      fv_d    = 1'b1;
      lk_d    = 1'b1;
      lcnt_d  = '0;
    end else if (lcnt_q != LT_MAX) begin
      lcnt_d = lcnt_q + 1'b1;
      if (lcnt_d == LT_MAX) lk_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_SYNC;
      exp_q   <= '0;
      wcnt_q  <= '0;
      lcnt_q  <= '0;
      sh_px_q <= RST_PL1_X;
      sh_py_q <= RST_PL1_Y;
      sh_bx_q <= '0;
      sh_by_q <= '0;
      px_q    <= RST_PL1_X;
      py_q    <= RST_PL1_Y;
      bx_q    <= '0;
      by_q    <= '0;
      s1_q    <= '0;
      s2_q    <= '0;
      fp_q    <= 1'b0;
      eg_q    <= 1'b0;
      wh_q    <= 1'b0;
      wprev_q <= 1'b0;
      fv_q    <= 1'b0;
      fe_q    <= 1'b0;
      lk_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      exp_q   <= exp_d;
      wcnt_q  <= wcnt_d;
      lcnt_q  <= lcnt_d;
      sh_px_q <= sh_px_d;
      sh_py_q <= sh_py_d;
      sh_bx_q <= sh_bx_d;
      sh_by_q <= sh_by_d;
      px_q    <= px_d;
      py_q    <= py_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      s1_q    <= s1_d;
      s2_q    <= s2_d;
      fp_q    <= fp_d;
      eg_q    <= eg_d;
      wh_q    <= wh_d;
      wprev_q <= wprev_d;
      fv_q    <= fv_d;
      fe_q    <= fe_d;
      lk_q    <= lk_d;
    end
  end

  assign pl1_posx    = px_q;
  assign pl1_posy    = py_q;
  assign ball_posx   = bx_q;
  assign ball_posy   = by_q;
  assign pl1_score   = s1_q;
  assign pl2_score   = s2_q;
  assign flag_point  = fp_q;
  assign end_game    = eg_q;
  assign whistle     = wh_q;
  assign frame_valid = fv_q;
  assign frame_err   = fe_q;
  assign link_ok     = lk_q;

endmodule

// File: tb/tb_uart_frame_demux.sv
module tb_uart_frame_demux;

  localparam int WT = 40;
  localparam int LT = 300;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] data_in = '0;
  logic        data_valid = 1'b0;
  logic [11:0] pl1_posx, pl1_posy, ball_posx, ball_posy;
  logic [3:0]  pl1_score, pl2_score;
  logic        flag_point, end_game, whistle, frame_valid, frame_err, link_ok;

  uart_frame_demux #(
    .WORD_TIMEOUT(WT),
    .LINK_TIMEOUT(LT),
    .RST_PL1_X(12'd50),
    .RST_PL1_Y(12'd679)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
    .pl1_posx(pl1_posx), .pl1_posy(pl1_posy),
    .ball_posx(ball_posx), .ball_posy(ball_posy),
    .pl1_score(pl1_score), .pl2_score(pl2_score),
    .flag_point(flag_point), .end_game(end_game), .whistle(whistle),
    .frame_valid(frame_valid), .frame_err(frame_err), .link_ok(link_ok)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: the frame in progress is a queue of received payloads;
  // the next acceptable tag is simply its length.
  logic [11:0] fq[$];
  int          idle, since;
  logic        prev_wh;
  logic [11:0] e_px, e_py, e_bx, e_by;
  logic [3:0]  e_s1, e_s2;
  logic        e_fp, e_eg, e_wh, e_fv, e_fe, e_lk;
  int          cnt_fe, cnt_wh, cnt_fv;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    assert (act === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic r, input logic v, input logic [15:0] d);
    int          tg;
    logic [11:0] pay;
    logic        committed;
    tg = int'(d[15:12]);
    pay = d[11:0];
    committed = 1'b0;
    e_wh = 1'b0; e_fv = 1'b0; e_fe = 1'b0;
    if (r) begin
      fq.delete(); idle = 0; since = 0; prev_wh = 1'b0;
      e_px = 12'd50; e_py = 12'd679; e_bx = '0; e_by = '0;
      e_s1 = '0; e_s2 = '0; e_fp = 1'b0; e_eg = 1'b0; e_lk = 1'b0;
      return;
    end
    if (fq.size() > 0) begin
      if (v) begin
        idle = 0;
        if (tg == fq.size()) begin
          if (tg < 4) fq.push_back(pay);
          else begin
            e_px = fq[0]; e_py = fq[1]; e_bx = fq[2]; e_by = fq[3];
            e_s1 = pay[11:8]; e_s2 = pay[7:4]; e_fp = pay[3]; e_eg = pay[2];
            e_wh = pay[1] && !prev_wh;
            prev_wh = pay[1];
            e_fv = 1'b1;
            committed = 1'b1;
            fq.delete();
          end
        end else if (tg == 0) begin
          e_fe = 1'b1;
          fq.delete();
          fq.push_back(pay);
        end else begin
          e_fe = 1'b1;
          fq.delete();
        end
      end else begin
        idle++;
        if (idle == WT) begin
          e_fe = 1'b1;
          fq.delete();
        end
      end
    end else if (v && tg == 0) begin
      fq.push_back(pay);
      idle = 0;
    end
    if (committed) begin
      since = 0;
      e_lk = 1'b1;
    end else if (since < LT) begin
      since++;
      if (since == LT) e_lk = 1'b0;
    end
  endtask

  task automatic check_all();
    chk("pl1_posx", 32'(pl1_posx), 32'(e_px));
    chk("pl1_posy", 32'(pl1_posy), 32'(e_py));
    chk("ball_posx", 32'(ball_posx), 32'(e_bx));
    chk("ball_posy", 32'(ball_posy), 32'(e_by));
    chk("scores", 32'({pl1_score, pl2_score}), 32'({e_s1, e_s2}));
    chk("flags", 32'({flag_point, end_game}), 32'({e_fp, e_eg}));
    chk("whistle", 32'(whistle), 32'(e_wh));
    chk("frame_valid", 32'(frame_valid), 32'(e_fv));
    chk("frame_err", 32'(frame_err), 32'(e_fe));
    chk("link_ok", 32'(link_ok), 32'(e_lk));
    if (frame_err) cnt_fe++;
    if (whistle) cnt_wh++;
    if (frame_valid) cnt_fv++;
  endtask

  task automatic cyc(input logic r, input logic v, input logic [15:0] d);
    @(negedge clk);
    rst = r; data_valid = v; data_in = d;
    @(posedge clk);
    model_step(r, v, d);
    #1;
    check_all();
  endtask

  task automatic word(input logic [15:0] d);
    cyc(1'b0, 1'b1, d);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 16'h0000);
  endtask

  task automatic frame(input logic [11:0] a, input logic [11:0] b, input logic [11:0] c,
                       input logic [11:0] e, input logic [11:0] st);
    word({4'h0, a}); word({4'h1, b}); word({4'h2, c}); word({4'h3, e}); word({4'h4, st});
  endtask

  initial begin
    fq.delete(); idle = 0; since = 0; prev_wh = 1'b0;
    cnt_fe = 0; cnt_wh = 0; cnt_fv = 0;

    // Reset state
    cyc(1'b1, 1'b0, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("rst_px", 32'(pl1_posx), 32'd50);
    chk("rst_py", 32'(pl1_posy), 32'd679);
    chk("rst_link", 32'(link_ok), 32'd0);
    idle_n(2);

    // 1: reference frame
    word(16'h0064); word(16'h12A7); word(16'h2200); word(16'h3150); word(16'h4A3A);
    chk("t1_px", 32'(pl1_posx), 32'd100);
    chk("t1_py", 32'(pl1_posy), 32'd679);
    chk("t1_bx", 32'(ball_posx), 32'd512);
    chk("t1_by", 32'(ball_posy), 32'd336);
    chk("t1_s1", 32'(pl1_score), 32'd10);
    chk("t1_s2", 32'(pl2_score), 32'd3);
    chk("t1_pulses", 32'({flag_point, end_game, whistle, frame_valid, link_ok}), 32'b10111);
    idle_n(2);

    // 2: missing tag 2, then a good frame
    word(16'h0011); word(16'h1022); word(16'h3033);
    chk("t2_err", 32'(frame_err), 32'd1);
    chk("t2_hold", 32'(pl1_posx), 32'd100);
    frame(12'd7, 12'd8, 12'd9, 12'd10, 12'h120);
    chk("t2_commit", 32'(pl1_posx), 32'd7);

    // 3: restart on a second tag 0
    cnt_fe = 0;
    word(16'h0005); word(16'h1006);
    frame(12'd300, 12'd301, 12'd302, 12'd303, 12'h000);
    chk("t3_errs", 32'(cnt_fe), 32'd1);
    chk("t3_px", 32'(pl1_posx), 32'd300);

    // 4: word timeout, then link loss
    cnt_fe = 0;
    word(16'h0AAA); word(16'h1BBB);
    idle_n(WT + 2);
    chk("t4_errs", 32'(cnt_fe), 32'd1);
    chk("t4_hold", 32'(pl1_posx), 32'd300);
    idle_n(LT);
    chk("t4_link", 32'(link_ok), 32'd0);
    chk("t4_hold2", 32'(ball_posx), 32'd302);

    // 5: whistle edge only once; stray tags in idle ignored
    cnt_wh = 0; cnt_fe = 0;
    frame(12'd1, 12'd2, 12'd3, 12'd4, 12'h002);
    idle_n(1);
    frame(12'd1, 12'd2, 12'd3, 12'd4, 12'h002);
    word(16'h2123); word(16'h4002);
    chk("t5_whistle", 32'(cnt_wh), 32'd1);
    chk("t5_noerr", 32'(cnt_fe), 32'd0);

    // 6: reset mid-frame
    word(16'h0321); word(16'h1321); word(16'h2321);
    cyc(1'b1, 1'b0, 16'h0000);
    chk("t6_px", 32'(pl1_posx), 32'd50);
    chk("t6_flags", 32'({frame_err, link_ok, pl1_score}), 32'd0);
    frame(12'd11, 12'd12, 12'd13, 12'd14, 12'h556);
    chk("t6_commit", 32'(ball_posy), 32'd14);

    // Randomized traffic against the model
    cnt_fv = 0;
    for (int f = 0; f < 80; f++) begin
      for (int t = 0; t < 5; t++) begin
        logic [3:0]  tg;
        logic [11:0] p;
        tg = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15)) : 4'(t);
        p = 12'($urandom);
        word({tg, p});
        if ($urandom_range(0, 2) == 0) idle_n(int'($urandom_range(1, 3)));
        if ($urandom_range(0, 60) == 0) idle_n(WT);
      end
    end
    chk("rand_some_commits", 32'(cnt_fv > 10), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
